// File: rtl/mem_wb_pkg.sv
// Shared types for the MEM/WB stage: writeback source select and the payload
// carried through the head and skid registers.
package mem_wb_pkg;

    localparam int MW_DATA_W = 16;
    localparam int MW_LANES  = 4;
    localparam int MW_REG_W  = 4;
    localparam int MW_PC_W   = 16;
    localparam int MW_CNT_W  = 32;
    localparam int MW_VEC_W  = MW_LANES * MW_DATA_W;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_MEM  = 2'b01,
        RES_PC2  = 2'b10,
        RES_ZERO = 2'b11
    } result_src_e;

    typedef struct packed {
        logic                 reg_write;
        logic                 vec;
        result_src_e          result_src;
        logic [MW_REG_W-1:0]  rd;
        logic [MW_VEC_W-1:0]  alu_res;
        logic [MW_VEC_W-1:0]  read_data;
        logic [MW_PC_W-1:0]   pc_plus2;
    } payload_t;

endpackage

// File: rtl/mem_wb_stage_result_mux.sv
// Combinational writeback result selection; also instantiated by the
// forwarding unit so both see identical result vectors.
module wb_result_mux
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = MW_DATA_W,
    parameter int LANES  = MW_LANES,
    parameter int PC_W   = MW_PC_W
) (
    input  result_src_e              result_src_i,
    input  logic [LANES*DATA_W-1:0]  alu_res_i,
    input  logic [LANES*DATA_W-1:0]  read_data_i,
    input  logic [PC_W-1:0]          pc_plus2_i,
    output logic [LANES*DATA_W-1:0]  result_o
);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DATA_W-1:0] pc_lane;

            // Only the scalar lane carries the return address.
            if (gi == 0) begin : g_pc
                if (PC_W >= DATA_W) begin : g_trunc
                    assign pc_lane = pc_plus2_i[DATA_W-1:0];
                end else begin : g_zext
                    assign pc_lane = {{(DATA_W-PC_W){1'b0}}, pc_plus2_i};
                end
            end else begin : g_nopc
                assign pc_lane = '0;
            end

            assign result_o[gi*DATA_W +: DATA_W] =
                (result_src_i == RES_ALU) ? alu_res_i[gi*DATA_W +: DATA_W]   :
                (result_src_i == RES_MEM) ? read_data_i[gi*DATA_W +: DATA_W] :
                (result_src_i == RES_PC2) ? pc_lane                           :
                                            '0;
        end
    endgenerate

endmodule

// File: rtl/mem_wb_stage.sv
// Elastic MEM/WB stage: head register drives WB, a skid register absorbs one
// extra entry so the registered in_ready never loses a transaction.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = MW_DATA_W,
    parameter int LANES  = MW_LANES,
    parameter int REG_W  = MW_REG_W,
    parameter int PC_W   = MW_PC_W,
    parameter int CNT_W  = MW_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     reg_write_in,
    input  logic                     vec_in,
    input  logic [1:0]               result_src_in,
    input  logic [REG_W-1:0]         rd_in,
    input  logic [LANES*DATA_W-1:0]  alu_res_in,
    input  logic [LANES*DATA_W-1:0]  read_data_in,
    input  logic [PC_W-1:0]          pc_plus2_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     reg_write_out,
    output logic                     vec_out,
    output logic [REG_W-1:0]         rd_out,
    output logic [LANES*DATA_W-1:0]  result_out,
    output logic [CNT_W-1:0]         retired
);

    payload_t          head_q, head_d;
    payload_t          skid_q, skid_d;
    payload_t          in_payload;
    logic              head_valid_q, head_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              accept;
    logic              consume;

    always_comb begin
        in_payload            = '0;
        in_payload.reg_write  = reg_write_in;
        in_payload.vec        = vec_in;
        in_payload.result_src = result_src_e'(result_src_in);
        in_payload.rd         = rd_in;
        in_payload.alu_res    = alu_res_in;
        in_payload.read_data  = read_data_in;
        in_payload.pc_plus2   = pc_plus2_in;
    end

    assign accept  = in_valid & in_ready_q;
    assign consume = head_valid_q & out_ready;

    always_comb begin
        head_d       = head_q;
        skid_d       = skid_q;
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (consume && skid_valid_q) begin
                head_d       = skid_q;
                head_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (!head_valid_q || consume) begin
                head_valid_d = accept;
                if (accept) begin
                    head_d = in_payload;
                end
            end

            // accept implies the skid is empty, so this never overwrites it.
            if (accept && head_valid_q && !consume) begin
                skid_d       = in_payload;
                skid_valid_d = 1'b1;
            end
        end

        in_ready_d = ~skid_valid_d;
        retired_d  = retired_q;
        if (consume && head_q.reg_write) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q       <= '0;
            skid_q       <= '0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            retired_q    <= '0;
        end else begin
            head_q       <= head_d;
            skid_q       <= skid_d;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            retired_q    <= retired_d;
        end
    end

    wb_result_mux #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .PC_W   (PC_W)
    ) u_result_mux (
        .result_src_i (head_q.result_src),
        .alu_res_i    (head_q.alu_res),
        .read_data_i  (head_q.read_data),
        .pc_plus2_i   (head_q.pc_plus2),
        .result_o     (result_out)
    );

    assign in_ready      = in_ready_q;
    assign out_valid     = head_valid_q;
    assign reg_write_out = head_q.reg_write & head_valid_q;
    assign vec_out       = head_q.vec;
    assign rd_out        = head_q.rd;
    assign retired       = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: table-driven vectors feed a scoreboard
// queue that is checked whenever WB consumes the head entry.
module tb_mem_wb_stage;

    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        reg_write_in;
    logic        vec_in;
    logic [1:0]  result_src_in;
    logic [3:0]  rd_in;
    logic [63:0] alu_res_in;
    logic [63:0] read_data_in;
    logic [15:0] pc_plus2_in;
    logic        out_valid;
    logic        out_ready;
    logic        reg_write_out;
    logic        vec_out;
    logic [3:0]  rd_out;
    logic [63:0] result_out;
    logic [CNT_W-1:0] retired;

    always #5 clk = ~clk;

    mem_wb_stage #(
        .DATA_W (16),
        .LANES  (4),
        .REG_W  (4),
        .PC_W   (16),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .reg_write_in  (reg_write_in),
        .vec_in        (vec_in),
        .result_src_in (result_src_in),
        .rd_in         (rd_in),
        .alu_res_in    (alu_res_in),
        .read_data_in  (read_data_in),
        .pc_plus2_in   (pc_plus2_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .reg_write_out (reg_write_out),
        .vec_out       (vec_out),
        .rd_out        (rd_out),
        .result_out    (result_out),
        .retired       (retired)
    );

    typedef struct {
        logic        rw;
        logic        vec;
        logic [1:0]  src;
        logic [3:0]  rd;
        logic [63:0] alu;
        logic [63:0] rdata;
        logic [15:0] pc;
        logic [63:0] exp;
    } vec_t;

    typedef struct packed {
        logic        rw;
        logic        vec;
        logic [3:0]  rd;
        logic [63:0] res;
    } sb_t;

    vec_t        tbl [8];
    sb_t         sb [$];
    sb_t         cur;
    logic [CNT_W-1:0] retired_m;
    int          checks;
    int          errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid      = 1'b1;
        reg_write_in  = v.rw;
        vec_in        = v.vec;
        result_src_in = v.src;
        rd_in         = v.rd;
        alu_res_in    = v.alu;
        read_data_in  = v.rdata;
        pc_plus2_in   = v.pc;
        cur           = '{rw: v.rw, vec: v.vec, rd: v.rd, res: v.exp};
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Compare at the falling edge, update the model, then move past the next rising edge.
    task automatic cycle();
        bit acc;
        bit cons;
        @(negedge clk);
        acc  = in_valid && (sb.size() < 2);
        cons = out_ready && (sb.size() > 0);
        chk("retired", retired, retired_m);
        chk("out_valid", out_valid, sb.size() > 0);
        chk("in_ready", in_ready, sb.size() < 2);
        if (cons) begin
            chk("rd_out", rd_out, sb[0].rd);
            chk("vec_out", vec_out, sb[0].vec);
            chk("reg_write_out", reg_write_out, sb[0].rw);
            chk("result_out", result_out, sb[0].res);
            $display("consume rd=%0d vec=%0b rw=%0b result=%h", rd_out, vec_out, reg_write_out, result_out);
            if (sb[0].rw) retired_m = retired_m + 1'b1;
            void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            chk("reg_write_out_idle", reg_write_out, 1'b0);
        end
        if (flush) sb.delete();
        else if (acc) sb.push_back(cur);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0; errors = 0; retired_m = '0;
        tbl[0] = '{1'b1, 1'b0, 2'b00, 4'd1, 64'h3333_2222_1111_1234, 64'h0, 16'h0, 64'h3333_2222_1111_1234};
        tbl[1] = '{1'b1, 1'b0, 2'b00, 4'd2, 64'h0004_0003_0002_BEEF, 64'h0, 16'h0, 64'h0004_0003_0002_BEEF};
        tbl[2] = '{1'b1, 1'b0, 2'b00, 4'd3, 64'h0000_0000_0000_0001, 64'h0, 16'h0, 64'h0000_0000_0000_0001};
        tbl[3] = '{1'b1, 1'b0, 2'b10, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5555_5555_5555_5555, 16'h00A2, 64'h0000_0000_0000_00A2};
        tbl[4] = '{1'b1, 1'b1, 2'b11, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, 64'h0};
        tbl[5] = '{1'b1, 1'b1, 2'b01, 4'd6, 64'h1234_1234_1234_1234, 64'hCAFE_CAFE_CAFE_CAFE, 16'h0, 64'hCAFE_CAFE_CAFE_CAFE};
        tbl[6] = '{1'b0, 1'b1, 2'b00, 4'd15, 64'h0123_4567_89AB_CDEF, 64'h0, 16'h1, 64'h0123_4567_89AB_CDEF};
        tbl[7] = '{1'b1, 1'b1, 2'b10, 4'd7, 64'h0, 64'h0, 16'hFFFE, 64'h0000_0000_0000_FFFE};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        reg_write_in = 1'b0; vec_in = 1'b0; result_src_in = 2'b00; rd_in = '0;
        alu_res_in = '0; read_data_in = '0; pc_plus2_in = '0; cur = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset then idle.
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_retired", retired, '0);
        chk("rst_result_out", result_out, '0);
        chk("rst_reg_write_out", reg_write_out, 1'b0);
        chk("rst_rd_out", rd_out, '0);
        @(posedge clk); #1;

        // Streaming: first three, then the mux vectors.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin drive(tbl[i]); cycle(); end
        idle(); cycle(); cycle();
        chk("stream_retired3", retired, 4'd3);
        for (int i = 3; i < 8; i++) begin drive(tbl[i]); cycle(); end
        idle(); cycle(); cycle();

        // Back-pressure: A held, B in skid, C offered while full.
        out_ready = 1'b0;
        drive(tbl[0]); cycle();
        drive(tbl[1]); cycle();
        chk("bp_in_ready_low", in_ready, 1'b0);
        drive(tbl[2]); cycle();
        idle(); cycle();
        out_ready = 1'b1;
        cycle(); cycle(); cycle();

        // Flush with head and skid full.
        out_ready = 1'b0;
        drive(tbl[3]); cycle();
        drive(tbl[4]); cycle();
        drive(tbl[5]); flush = 1'b1; cycle();
        flush = 1'b0; idle();
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        cycle(); cycle();

        // Flush with consume and an accepted input in the same cycle.
        out_ready = 1'b0;
        drive(tbl[7]); cycle();
        out_ready = 1'b1;
        drive(tbl[1]); flush = 1'b1; cycle();
        flush = 1'b0; idle();
        cycle(); cycle();

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        drive(tbl[0]); cycle();
        drive(tbl[1]); cycle();
        idle();
        #2 reset = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_in_ready", in_ready, 1'b1);
        chk("async_rst_retired", retired, '0);
        sb.delete(); retired_m = '0;
        @(posedge clk); #1 reset = 1'b0;
        out_ready = 1'b1;
        cycle();

        // Retire counter wrap at 4 bits.
        for (int i = 0; i < 17; i++) begin drive(tbl[0]); cycle(); end
        idle(); cycle(); cycle();
        chk("wrap_retired", retired, 4'd1);
        drive(tbl[6]); cycle();
        idle(); cycle(); cycle();
        chk("no_rw_retired", retired, 4'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
